// File: rtl/dmem_responder_pkg.sv
// +----------------------------------------------------------------------+
// | dmem_responder_pkg : shared size/state encodings and request record  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package dmem_responder_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == SIZE_H) && lane[0]) || ((size == SIZE_W) && (lane != 2'd0));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// +----------------------------------------------------------------------+
// | dmem_lane_align : store lane merge and load shift/extend             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_wr_word
);

  logic [4:0]  w_shamt;
  logic [31:0] w_rd_shift;
  logic [31:0] w_wd_shift;
  logic [3:0]  w_be;

  assign w_shamt    = {i_lane, 3'b000};
  assign w_rd_shift = i_rd_word >> w_shamt;
  assign w_wd_shift = i_wdata << w_shamt;

  always_comb begin
    case (i_size)
      SIZE_B:  w_be = 4'b0001 << i_lane;
      SIZE_H:  w_be = 4'b0011 << i_lane;
      default: w_be = 4'b1111;
    endcase
  end

  // Unselected lanes keep the current word so partial stores are read-modify-write.
  always_comb begin
    o_wr_word = i_rd_word;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) o_wr_word[8*b +: 8] = w_wd_shift[8*b +: 8];
    end
  end

  always_comb begin
    case (i_size)
      SIZE_B:  o_ld_data = {{24{~i_unsigned & w_rd_shift[7]}}, w_rd_shift[7:0]};
      SIZE_H:  o_ld_data = {{16{~i_unsigned & w_rd_shift[15]}}, w_rd_shift[15:0]};
      default: o_ld_data = w_rd_shift;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +----------------------------------------------------------------------+
// | dmem_responder : single-outstanding data memory with fixed latency   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         c_aw        = $clog2(DEPTH);
  localparam logic [3:0] c_wait_load = 4'((WAIT > 0) ? WAIT - 1 : 0);

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [3:0]      r_cnt;
  logic            r_armed;
  dmem_req_t       r_req;
  dmem_req_t       w_op;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_go_resp;
  logic            w_err;
  logic [c_aw-1:0] w_idx;
  logic [31:0]     w_rd_word;
  logic [31:0]     w_ld_data;
  logic [31:0]     w_wr_word;

  assign w_accept = req_valid & req_ready;

  // With WAIT = 0 the access happens on the accept edge, so it uses the live inputs.
  assign w_op = (r_state == ST_IDLE)
              ? {req_we, req_size, req_unsigned, req_addr, req_wdata}
              : r_req;

  assign w_idx     = w_op.addr[c_aw+1:2];
  assign w_rd_word = r_mem[w_idx];
  assign w_err     = misaligned(w_op.size, w_op.addr[1:0])
                   || ((w_op.addr >> (c_aw + 2)) != 32'd0)
                   || (w_op.size == 2'd3);
  assign w_go_resp = (w_next == ST_RESP) && (r_state != ST_RESP);

  dmem_lane_align u_align (
    .i_size     (w_op.size),
    .i_unsigned (w_op.is_unsigned),
    .i_lane     (w_op.addr[1:0]),
    .i_rd_word  (w_rd_word),
    .i_wdata    (w_op.wdata),
    .o_ld_data  (w_ld_data),
    .o_wr_word  (w_wr_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (WAIT > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE) && r_armed;
    rsp_valid = (r_state == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed <= 1'b0;
      r_cnt   <= 4'd0;
      r_req   <= '0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_req <= w_op;
        if (WAIT > 0) r_cnt <= c_wait_load;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_go_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_op.we) ? 32'd0 : w_ld_data;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_go_resp && w_op.we && !w_err) r_mem[w_idx] <= w_wr_word;
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words of storage (power of two, >= 4).
REQ-002 SHALL have parameter WAIT, default 1, meaning added wait cycles between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  a load/store request is presented.
REQ-006 SHALL have port req_ready  output  1  the responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-009 SHALL have port req_unsigned  input  1  for loads, zero-extend instead of sign-extend.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  output  1  a response is presented.
REQ-013 SHALL have port rsp_ready  input  1  the requester consumes the response this cycle.
REQ-014 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  the request was misaligned, out of range, or had size 3.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-018 SHALL latch we, size, unsigned, addr and wdata on accept, and ignore request inputs until the FSM returns to IDLE.
REQ-019 SHALL go from IDLE to WAIT on accept when WAIT > 0, loading the wait counter with WAIT-1; with WAIT = 0 it SHALL go directly to RESP.
REQ-020 SHALL decrement the counter in WAIT and go to RESP on the cycle the counter is 0.
REQ-021 SHALL perform the memory read or write on the transition into RESP; the first rsp_valid cycle is therefore accept+WAIT+1.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on the next edge.
REQ-023 SHALL NOT accept a new request in the same cycle as a response handshake (no back-to-back overlap; minimum issue interval WAIT+2 cycles).
REQ-024 SHALL index the word as addr[log2(DEPTH)+1:2] and select lanes from addr[1:0].
REQ-025 SHALL flag a misalignment error when a half access has addr[0] = 1, or a word access has addr[1:0] != 0.
REQ-026 SHALL flag a range error when addr >= 4*DEPTH, and an error when size = 3.
REQ-027 SHALL suppress the write on any error, return rdata 0, and set rsp_err = 1.
REQ-028 SHALL write only the addressed byte lanes on a store (byte = 1 lane, half = 2 lanes, word = 4 lanes) and leave the other lanes unchanged.
REQ-029 SHALL shift a load right by 8*addr[1:0] and then sign- or zero-extend it to 32 bits per req_unsigned.

Reset
REQ-030 SHALL, while reset = 0, force IDLE state, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 and req_ready 0.
REQ-031 SHALL drop any in-flight request when reset is asserted mid-operation, with no memory write.
REQ-032 SHALL NOT clear memory contents on reset.
REQ-033 SHALL raise req_ready on the first clk edge after reset deasserts.

Structure
REQ-034 SHALL take the size encodings (SIZE_B, SIZE_H, SIZE_W) and the FSM state encodings from the shared package used by the core.
REQ-035 SHALL place the lane-select/extend logic in one combinational sub-module named dmem_lane_align; storage SHALL stay inline.

Verification
REQ-036 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0; with WAIT = 1, rsp_valid rises exactly 2 cycles after accept.
REQ-037 SB 0x13 data 0x80 over word 0; then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-038 LH 0x11 -> err 1, rdata 0; SW 0x12 -> err 1 and word at 0x10 unchanged; size 3 -> err 1.
REQ-039 LW 4*DEPTH -> err 1; SW 4*DEPTH-4 data 0x12345678, then LW 4*DEPTH-4 -> 0x12345678.
REQ-040 Hold rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable and req_ready = 0 throughout; a req_valid pulse during RESP is not accepted.
REQ-041 Assert reset during WAIT of an SW to 0x20 -> outputs reach reset values immediately; a later LW 0x20 returns the prior contents.
